// File: rtl/simd_alu_pkg.sv
// Shared types and constants for the SIMD ALU datapath (adder, shifter and
// the shifter operand-issue stage).
package simd_alu_pkg;

  localparam int SIMD_DATA_WIDTH            = 256;
  localparam int SIMD_ADDER_DATA_MODE_WIDTH = 2;

  // Lane-size code carried on data_mode.
  typedef enum logic [1:0] {
    MODE_8  = 2'd0,
    MODE_16 = 2'd1,
    MODE_32 = 2'd2,
    MODE_64 = 2'd3
  } simd_mode_e;

  // One shifter request as held in the issue-stage registers.
  typedef struct packed {
    logic [SIMD_DATA_WIDTH-1:0]            a;
    logic [SIMD_DATA_WIDTH-1:0]            b;
    logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] data_mode;
    logic                                  left;
  } shift_req_t;

  // Lane width in bits for a lane-size code.
  function automatic int lane_width(input simd_mode_e mode);
    return 8 << mode;
  endfunction

endpackage

// File: rtl/simd_alu_shift_count_prep.sv
// Combinational shift-count normalisation: optional broadcast of a scalar
// count from b[7:0] to every lane, then a per-lane clamp to the lane width
// so a count of W (or more) means "every bit shifted out".
module simd_alu_shift_count_prep #(
  parameter int SIMD_DATA_WIDTH            = 256,
  parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2
) (
  input  logic [SIMD_DATA_WIDTH-1:0]            i_b,
  input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] i_data_mode,
  input  logic                                  i_scalar,
  output logic [SIMD_DATA_WIDTH-1:0]            o_b
);
  import simd_alu_pkg::*;

  // Normalised counts computed for every lane size; the mode picks one.
  logic [3:0][SIMD_DATA_WIDTH-1:0] w_b_by_mode;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    localparam int LW = lane_width(simd_mode_e'(m));
    localparam int NL = SIMD_DATA_WIDTH / LW;
    for (genvar l = 0; l < NL; l++) begin : g_lane
      logic [LW-1:0] w_raw;
      assign w_raw = i_scalar ? LW'(i_b[7:0]) : i_b[l*LW +: LW];
      // Unsigned clamp: anything past the lane width saturates at LW.
      assign w_b_by_mode[m][l*LW +: LW] = (w_raw > LW'(LW)) ? LW'(LW) : w_raw;
    end
  end

  // Select the normalised count vector for the requested lane size.
  always_comb begin
    o_b = w_b_by_mode[3];
    case (i_data_mode)
      MODE_8:  o_b = w_b_by_mode[0];
      MODE_16: o_b = w_b_by_mode[1];
      MODE_32: o_b = w_b_by_mode[2];
      MODE_64: o_b = w_b_by_mode[3];
      default: o_b = w_b_by_mode[3];
    endcase
  end

endmodule

// File: rtl/simd_alu_shift_operand_stage.sv
// Registered operand-issue stage in front of the SIMD shifter. Counts are
// normalised on the input side, then the request is held in a 2-entry skid
// buffer (main M drives the outputs, skid S catches the one request that
// arrives while M is stalled).
//
// Handshake: a transfer happens on a rising edge when valid & ready are both
// high on that side. Once out_valid is high, out_* hold steady until the
// edge where out_ready is seen high. in_ready is a function of registered
// state and rst only, never of out_ready.
//
// The widths of shift_req_t come from simd_alu_pkg, so the parameters must
// match the package constants.
module simd_alu_shift_operand_stage #(
  parameter int SIMD_DATA_WIDTH            = 256,
  parameter int SIMD_ADDER_DATA_MODE_WIDTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [SIMD_DATA_WIDTH-1:0]            in_a,
  input  logic [SIMD_DATA_WIDTH-1:0]            in_b,
  input  logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] in_data_mode,
  input  logic                                  in_left,
  input  logic                                  in_scalar,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [SIMD_DATA_WIDTH-1:0]            out_a,
  output logic [SIMD_DATA_WIDTH-1:0]            out_b,
  output logic [SIMD_ADDER_DATA_MODE_WIDTH-1:0] out_data_mode,
  output logic                                  out_left,
  output logic [1:0]                            o_dbg_state
);
  import simd_alu_pkg::*;

  // Buffer occupancy encoded as {S.valid, M.valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } buf_state_e;

  buf_state_e r_state;
  shift_req_t r_m;
  shift_req_t r_s;

  logic [SIMD_DATA_WIDTH-1:0] w_b_norm;
  shift_req_t                 w_req;
  logic                       w_accept;
  logic                       w_drain;

  simd_alu_shift_count_prep #(
    .SIMD_DATA_WIDTH            (SIMD_DATA_WIDTH),
    .SIMD_ADDER_DATA_MODE_WIDTH (SIMD_ADDER_DATA_MODE_WIDTH)
  ) u_count_prep (
    .i_b         (in_b),
    .i_data_mode (in_data_mode),
    .i_scalar    (in_scalar),
    .o_b         (w_b_norm)
  );

  // Incoming request with its counts already normalised.
  always_comb begin
    w_req           = '0;
    w_req.a         = in_a;
    w_req.b         = w_b_norm;
    w_req.data_mode = in_data_mode;
    w_req.left      = in_left;
  end

  assign in_ready  = ~rst & (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_drain   = out_valid & out_ready;

  // Skid-buffer control: occupancy plus M/S data movement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_m     <= '0;
      r_s     <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m     <= w_req;
            r_state <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            r_m <= w_req;
          end else if (w_accept) begin
            r_s     <= w_req;
            r_state <= ST_FULL;
          end else if (w_drain) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can happen.
          if (w_drain) begin
            r_m     <= r_s;
            r_s     <= '0;
            r_state <= ST_ONE;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
    end
  end

  assign out_a         = r_m.a;
  assign out_b         = r_m.b;
  assign out_data_mode = r_m.data_mode;
  assign out_left      = r_m.left;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_simd_alu_shift_operand_stage.sv
// Bench for the shifter operand-issue stage: directed scenarios plus a
// randomized stream, checked against a lane-by-lane arithmetic model and a
// queue of expected entries in acceptance order.
module tb_simd_alu_shift_operand_stage;

  localparam int DW = 256;
  localparam int MW = 2;
  localparam int RW = 2 * DW + MW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [MW-1:0] in_data_mode;
  logic          in_left;
  logic          in_scalar;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;
  logic [MW-1:0] out_data_mode;
  logic          out_left;
  logic [1:0]    o_dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_drained = 0;
  logic [RW-1:0] exp_q[$];

  simd_alu_shift_operand_stage #(
    .SIMD_DATA_WIDTH            (DW),
    .SIMD_ADDER_DATA_MODE_WIDTH (MW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_data_mode  (in_data_mode),
    .in_left       (in_left),
    .in_scalar     (in_scalar),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_a         (out_a),
    .out_b         (out_b),
    .out_data_mode (out_data_mode),
    .out_left      (out_left),
    .o_dbg_state   (o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Normalised counts: per lane, raw = scalar byte or the lane's own bits,
  // then min(raw, lane width).
  function automatic logic [DW-1:0] ref_counts(input logic [DW-1:0] b,
                                               input logic [MW-1:0] mode,
                                               input logic scalar);
    int lw;
    int nl;
    logic [DW-1:0] r;
    longint unsigned raw;
    lw = 8 << mode;
    nl = DW / lw;
    r  = '0;
    for (int i = 0; i < nl; i++) begin
      raw = 0;
      if (scalar) raw = 64'(b[7:0]);
      else for (int k = 0; k < lw; k++) raw[k] = b[i*lw+k];
      if (raw > longint'(lw)) raw = longint'(lw);
      for (int k = 0; k < lw; k++) r[i*lw+k] = raw[k];
    end
    return r;
  endfunction

  // Lane-wise logical shift, as the downstream shifter would compute it.
  function automatic logic [DW-1:0] ref_shift(input logic [DW-1:0] a,
                                              input logic [DW-1:0] b,
                                              input logic [MW-1:0] mode,
                                              input logic left);
    int lw;
    int nl;
    logic [DW-1:0] r;
    longint unsigned va;
    longint unsigned vb;
    longint unsigned mask;
    lw   = 8 << mode;
    nl   = DW / lw;
    r    = '0;
    mask = (lw == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << lw) - 64'd1);
    for (int i = 0; i < nl; i++) begin
      va = 0;
      vb = 0;
      for (int k = 0; k < lw; k++) begin
        va[k] = a[i*lw+k];
        vb[k] = b[i*lw+k];
      end
      if (vb >= longint'(lw)) va = 0;
      else if (left) va = (va << vb) & mask;
      else va = va >> vb;
      for (int k = 0; k < lw; k++) r[i*lw+k] = va[k];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Counts biased so that both in-range and clamped lanes are common.
  function automatic logic [DW-1:0] rand_counts(input logic [MW-1:0] mode);
    int lw;
    logic [DW-1:0] v;
    logic [63:0] c;
    lw = 8 << mode;
    v  = rand_vec();
    for (int i = 0; i < DW / lw; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        c = 64'($urandom_range(0, 2 * lw));
        for (int k = 0; k < lw; k++) v[i*lw+k] = c[k];
      end
    end
    return v;
  endfunction

  // ---------------- driver + scoreboard ----------------
  // Called at a negedge with inputs already set for the coming edge.
  task automatic cycle(output bit acc);
    logic [RW-1:0] got;
    logic [RW-1:0] exp;
    bit stall;
    got   = {out_a, out_b, out_data_mode, out_left};
    stall = out_valid && !out_ready;
    if (out_valid && out_ready) begin
      n_cmp++;
      n_drained++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL drain_unexpected: got %h, required no entry", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL drain_data: got %h, required %h", got, exp);
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc)
      exp_q.push_back({in_a, ref_counts(in_b, in_data_mode, in_scalar), in_data_mode, in_left});
    @(posedge clk);
    @(negedge clk);
    if (stall) begin
      n_cmp++;
      if (!out_valid || {out_a, out_b, out_data_mode, out_left} !== got) begin
        n_fail++;
        $display("FAIL stall_stable: got v=%b %h, required v=1 %h", out_valid,
                 {out_a, out_b, out_data_mode, out_left}, got);
      end
    end
  endtask

  task automatic drain_all();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 8 && exp_q.size() > 0; c++) cycle(acc);
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_all: queue=%0d out_valid=%b, required 0/0", exp_q.size(), out_valid);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_a !== '0 || out_b !== '0 ||
        out_data_mode !== '0 || out_left !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: v=%b rdy=%b a=%h b=%h, required all 0",
               out_valid, in_ready, out_a, out_b);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: rdy=%b v=%b, required 1/0", in_ready, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_mode0_lanes();
    logic [DW-1:0] exp_b;
    logic [DW-1:0] a;
    bit acc;
    a = rand_vec();
    for (int i = 0; i < DW / 8; i++) begin
      in_b[i*8 +: 8]  = (i % 2 == 0) ? 8'd3 : 8'd9;
      exp_b[i*8 +: 8] = (i % 2 == 0) ? 8'd3 : 8'd8;
    end
    in_a = a; in_data_mode = 2'd0; in_left = 1'b1; in_scalar = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_b !== exp_b || out_a !== a) begin
      n_fail++;
      $display("FAIL mode0_clamp: v=%b b=%h, required v=1 b=%h", out_valid, out_b, exp_b);
    end
    drain_all();
  endtask

  task automatic test_mode2_scalar();
    logic [DW-1:0] exp_b;
    bit acc;
    exp_b = '0;
    for (int i = 0; i < DW / 32; i++) exp_b[i*32 +: 32] = 32'd5;
    in_b = rand_vec();
    in_b[7:0] = 8'h05;
    in_a = rand_vec(); in_data_mode = 2'd2; in_left = 1'b0; in_scalar = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_b !== exp_b || out_data_mode !== 2'd2) begin
      n_fail++;
      $display("FAIL mode2_scalar: v=%b b=%h, required v=1 b=%h", out_valid, out_b, exp_b);
    end
    drain_all();
  endtask

  task automatic test_mode3_saturate();
    logic [DW-1:0] exp_b;
    logic [DW-1:0] res;
    bit acc;
    exp_b = '0;
    for (int i = 0; i < DW / 64; i++) exp_b[i*64 +: 64] = 64'd64;
    for (int l = 0; l < 2; l++) begin
      in_b = rand_vec();
      in_b[7:0] = 8'hFF;
      in_a = rand_vec(); in_data_mode = 2'd3; in_left = l[0]; in_scalar = 1'b1;
      in_valid = 1'b1; out_ready = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_b !== exp_b || out_left !== l[0]) begin
        n_fail++;
        $display("FAIL mode3_clamp: v=%b left=%b b=%h, required v=1 left=%0d b=%h",
                 out_valid, out_left, out_b, l, exp_b);
      end
      res = ref_shift(out_a, out_b, out_data_mode, out_left);
      n_cmp++;
      if (res !== '0) begin
        n_fail++;
        $display("FAIL mode3_shift_zero: result %h, required 0", res);
      end
      drain_all();
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] a0, a1, a2;
    bit acc;
    a0 = rand_vec(); a1 = rand_vec(); a2 = rand_vec();
    in_data_mode = 2'd1; in_left = 1'b0; in_scalar = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = a0; in_b = rand_counts(2'd1); cycle(acc);
    in_a = a1; in_b = rand_counts(2'd1); cycle(acc);
    n_cmp++;
    if (in_ready !== 1'b0 || o_dbg_state !== 2'b11) begin
      n_fail++;
      $display("FAIL bp_full: rdy=%b state=%b, required 0/11", in_ready, o_dbg_state);
    end
    in_a = a2; in_b = rand_counts(2'd1); cycle(acc);
    n_cmp++;
    if (acc || in_ready !== 1'b0 || out_a !== a0) begin
      n_fail++;
      $display("FAIL bp_hold: acc=%b rdy=%b a=%h, required 0/0 a=%h", acc, in_ready, out_a, a0);
    end
    out_ready = 1'b1;
    cycle(acc);
    n_cmp++;
    if (in_ready !== 1'b1 || out_a !== a1) begin
      n_fail++;
      $display("FAIL bp_first_drain: rdy=%b a=%h, required 1 a=%h", in_ready, out_a, a1);
    end
    cycle(acc);
    n_cmp++;
    if (!acc || out_a !== a2 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_r2: acc=%b v=%b a=%h, required 1/1 a=%h", acc, out_valid, out_a, a2);
    end
    drain_all();
  endtask

  task automatic test_streaming();
    int sent;
    int d0;
    bit acc;
    sent = 0;
    d0   = n_drained;
    in_valid = 1'b1;
    in_data_mode = MW'($urandom_range(0, 3));
    in_a = rand_vec(); in_b = rand_counts(in_data_mode);
    in_left = 1'($urandom_range(0, 1)); in_scalar = ($urandom_range(0, 3) == 0);
    for (int c = 0; c < 3000 && sent < 100; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      cycle(acc);
      if (acc) begin
        sent++;
        in_data_mode = MW'($urandom_range(0, 3));
        in_a = rand_vec(); in_b = rand_counts(in_data_mode);
        in_left = 1'($urandom_range(0, 1)); in_scalar = ($urandom_range(0, 3) == 0);
      end
    end
    drain_all();
    n_cmp++;
    if (sent != 100 || n_drained - d0 != 100) begin
      n_fail++;
      $display("FAIL stream_count: sent=%0d drained=%0d, required 100/100", sent, n_drained - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] a;
    bit acc;
    in_data_mode = 2'd0; in_left = 1'b1; in_scalar = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1;
    in_a = rand_vec(); in_b = rand_counts(2'd0); cycle(acc);
    in_a = rand_vec(); in_b = rand_counts(2'd0); cycle(acc);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_a !== '0 || out_b !== '0 ||
        out_data_mode !== '0 || out_left !== 1'b0 || o_dbg_state !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid: v=%b rdy=%b state=%b a=%h, required all 0",
               out_valid, in_ready, o_dbg_state, out_a);
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_release: v=%b rdy=%b, required 0/1", out_valid, in_ready);
    end
    a = rand_vec();
    in_a = a; in_b = rand_counts(2'd0); in_valid = 1'b1;
    cycle(acc);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_a !== a) begin
      n_fail++;
      $display("FAIL reset_mid_latency: v=%b a=%h, required v=1 a=%h", out_valid, out_a, a);
    end
    drain_all();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_data_mode = '0; in_left = 1'b0; in_scalar = 1'b0;
    @(negedge clk);
    test_reset();
    test_mode0_lanes();
    test_mode2_scalar();
    test_mode3_saturate();
    test_backpressure();
    test_streaming();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
